// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM pipeline stage: access-size encodings and the
// EX/MEM and MEM/WB register layouts.
package memory_stage_pkg;

    typedef enum logic [1:0] {
        SIZE_WORD    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_BYTE    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } mem_size_e;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              mem_signed;
        mem_size_e         size;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] store_data;
    } ex_mem_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } mem_wb_t;

    function automatic logic access_legal(input mem_size_e size, input logic [1:0] lsb);
        case (size)
            SIZE_WORD: return (lsb == 2'b00);
            SIZE_HALF: return !lsb[0];
            SIZE_BYTE: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_data_memory.sv
// Word-organised data memory: combinational read, byte-enabled synchronous
// write. byte_en[3] addresses bits 31:24 (big-endian lane 0).
module data_memory
    import memory_stage_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        byte_en,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MIPS MEM stage: EX/MEM register, big-endian sub-word load/store against the
// data memory, MEM/WB register and sticky alignment-error flag.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              EX_Valid,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] StoreData,
    input  logic [REG_W-1:0]  RegDestSelected,
    input  logic              RegWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemToReg,
    input  logic              MemSigned,
    input  logic [1:0]        MemSize,
    input  logic              Stall,
    input  logic              Flush,
    output logic              MEM_RegWrite,
    output logic [REG_W-1:0]  MEM_RegDest,
    output logic [DATA_W-1:0] MEM_FwdData,
    output logic              WB_Valid,
    output logic              WB_RegWrite,
    output logic [REG_W-1:0]  WB_RegDest,
    output logic [DATA_W-1:0] WB_WriteData,
    output logic              AlignErr
);

    ex_mem_t           ex_mem, ex_mem_next;
    mem_wb_t           mem_wb, mem_wb_next;
    logic              align_err;
    logic [1:0]        lsb;
    logic              legal;
    logic              access_fault;
    logic [3:0]        byte_en;
    logic [DATA_W-1:0] store_lanes;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] load_data;
    logic [15:0]       load_half;
    logic [7:0]        load_byte;

    always_comb begin
        ex_mem_next            = '0;
        ex_mem_next.valid      = EX_Valid;
        ex_mem_next.reg_write  = RegWrite;
        ex_mem_next.mem_read   = MemRead;
        ex_mem_next.mem_write  = MemWrite;
        ex_mem_next.mem_to_reg = MemToReg;
        ex_mem_next.mem_signed = MemSigned;
        ex_mem_next.size       = mem_size_e'(MemSize);
        ex_mem_next.dest       = RegDestSelected;
        ex_mem_next.alu        = ALUResult;
        ex_mem_next.store_data = StoreData;
    end

    assign lsb          = ex_mem.alu[1:0];
    assign legal        = access_legal(ex_mem.size, lsb);
    assign access_fault = ex_mem.valid && (ex_mem.mem_read || ex_mem.mem_write) && !legal;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        byte_en     = '0;
        store_lanes = ex_mem.store_data;
        case (ex_mem.size)
            SIZE_WORD: byte_en = '1;
            SIZE_HALF: begin
                store_lanes = {2{ex_mem.store_data[15:0]}};
                byte_en     = lsb[1] ? 4'b0011 : 4'b1100;
            end
            SIZE_BYTE: begin
                store_lanes = {4{ex_mem.store_data[7:0]}};
                byte_en     = 4'b1000 >> lsb;
            end
            default: ;
        endcase
        if (!(ex_mem.valid && ex_mem.mem_write && legal) || Stall || Reset) begin
            byte_en = '0;
        end
    end

    data_memory #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_data_memory (
        .clk     (Clk),
        .addr    (ex_mem.alu[ADDR_W+1:2]),
        .byte_en (byte_en),
        .wdata   (store_lanes),
        .rdata   (rdata)
    );

    always_comb begin
        load_data = '0;
        load_half = lsb[1] ? rdata[15:0] : rdata[31:16];
        case (lsb)
            2'b00:   load_byte = rdata[31:24];
            2'b01:   load_byte = rdata[23:16];
            2'b10:   load_byte = rdata[15:8];
            default: load_byte = rdata[7:0];
        endcase
        case (ex_mem.size)
            SIZE_WORD: load_data = rdata;
            SIZE_HALF: load_data = {{16{ex_mem.mem_signed & load_half[15]}}, load_half};
            SIZE_BYTE: load_data = {{24{ex_mem.mem_signed & load_byte[7]}}, load_byte};
            default: ;
        endcase
        if (!legal) begin
            load_data = '0;
        end
    end

    always_comb begin
        mem_wb_next           = '0;
        mem_wb_next.valid     = ex_mem.valid;
        mem_wb_next.reg_write = ex_mem.valid & ex_mem.reg_write;
        mem_wb_next.dest      = ex_mem.dest;
        mem_wb_next.data      = ex_mem.mem_to_reg ? load_data : ex_mem.alu;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_mem    <= '0;
            mem_wb    <= '0;
            align_err <= 1'b0;
        end else if (!Stall) begin
            if (Flush) begin
                ex_mem <= '0;
            end else begin
                ex_mem <= ex_mem_next;
            end
            mem_wb <= mem_wb_next;
            if (access_fault) begin
                align_err <= 1'b1;
            end
        end
    end

    assign MEM_RegWrite = ex_mem.valid & ex_mem.reg_write;
    assign MEM_RegDest  = ex_mem.dest;
    assign MEM_FwdData  = ex_mem.alu;
    assign WB_Valid     = mem_wb.valid;
    assign WB_RegWrite  = mem_wb.reg_write;
    assign WB_RegDest   = mem_wb.dest;
    assign WB_WriteData = mem_wb.data;
    assign AlignErr     = align_err;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: issued instructions push their expected
// write-back; a negedge monitor pops and compares whenever WB advances.
module tb_memory_stage;

    logic        Clk;
    logic        Reset;
    logic        EX_Valid;
    logic [31:0] ALUResult;
    logic [31:0] StoreData;
    logic [4:0]  RegDestSelected;
    logic        RegWrite, MemRead, MemWrite, MemToReg, MemSigned;
    logic [1:0]  MemSize;
    logic        Stall, Flush;
    logic        MEM_RegWrite;
    logic [4:0]  MEM_RegDest;
    logic [31:0] MEM_FwdData;
    logic        WB_Valid, WB_RegWrite;
    logic [4:0]  WB_RegDest;
    logic [31:0] WB_WriteData;
    logic        AlignErr;

    localparam logic [1:0] SZ_W = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_B = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    logic adv;

    memory_stage #(
        .DEPTH  (1024),
        .ADDR_W (10)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .EX_Valid        (EX_Valid),
        .ALUResult       (ALUResult),
        .StoreData       (StoreData),
        .RegDestSelected (RegDestSelected),
        .RegWrite        (RegWrite),
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
        .MemToReg        (MemToReg),
        .MemSigned       (MemSigned),
        .MemSize         (MemSize),
        .Stall           (Stall),
        .Flush           (Flush),
        .MEM_RegWrite    (MEM_RegWrite),
        .MEM_RegDest     (MEM_RegDest),
        .MEM_FwdData     (MEM_FwdData),
        .WB_Valid        (WB_Valid),
        .WB_RegWrite     (WB_RegWrite),
        .WB_RegDest      (WB_RegDest),
        .WB_WriteData    (WB_WriteData),
        .AlignErr        (AlignErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // WB advanced on the last edge only when neither reset nor stall held it.
    always @(posedge Clk) adv <= !Reset && !Stall;

    always @(negedge Clk) begin
        if (adv && WB_Valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h expected nothing", WB_RegDest, WB_WriteData);
            end else begin
                mon_e = sb.pop_front();
                check("wb_out", {26'd0, WB_RegWrite, WB_RegDest, WB_WriteData}, {26'd0, mon_e});
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                         input logic m2r, input logic sg, input logic [1:0] sz,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd);
        EX_Valid = v; RegWrite = rw; MemRead = mr; MemWrite = mw; MemToReg = m2r;
        MemSigned = sg; MemSize = sz; RegDestSelected = rd; ALUResult = alu; StoreData = sd;
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SZ_W, 5'd0, 32'd0, 32'd0);
            cyc();
        end
    endtask

    task automatic op_alu(input logic [4:0] rd, input logic [31:0] val);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SZ_W, rd, val, 32'd0);
        sb.push_back({1'b1, rd, val});
        cyc();
    endtask

    task automatic op_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, sz, 5'd0, addr, data);
        sb.push_back({1'b0, 5'd0, addr});
        cyc();
    endtask

    task automatic op_load(input logic [1:0] sz, input logic sg, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] exp);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, sg, sz, rd, addr, 32'd0);
        sb.push_back({1'b1, rd, exp});
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SZ_W, 5'd3, 32'h55, 32'd0);
        repeat (3) cyc();
        @(negedge Clk);
        check("reset_mem_outs", {26'd0, MEM_RegWrite, MEM_RegDest, MEM_FwdData}, 64'd0);
        check("reset_wb_outs", {24'd0, WB_Valid, WB_RegWrite, WB_RegDest, WB_WriteData, AlignErr}, 64'd0);

        // Release reset with the same instruction still presented.
        Reset = 1'b0;
        sb.push_back({1'b1, 5'd3, 32'h55});
        cyc();
        @(negedge Clk);
        check("post_reset_mem", {57'd0, MEM_RegWrite, MEM_RegDest, 1'b0}, {57'd0, 1'b1, 5'd3, 1'b0});
        check("post_reset_wb", {62'd0, WB_Valid, WB_RegWrite}, 64'd0);
        bubble(1);

        op_store(SZ_W, 32'h10, 32'hDEADBEEF);
        op_load (SZ_W, 1'b0, 5'd5, 32'h10, 32'hDEADBEEF);
        op_load (SZ_B, 1'b1, 5'd6, 32'h11, 32'hFFFFFFAD);
        op_load (SZ_B, 1'b0, 5'd7, 32'h11, 32'h000000AD);
        op_store(SZ_W, 32'h20, 32'hAABBCCDD);
        op_store(SZ_H, 32'h22, 32'h00001234);
        op_load (SZ_W, 1'b0, 5'd5, 32'h20, 32'hAABB1234);
        op_load (SZ_H, 1'b1, 5'd6, 32'h20, 32'hFFFFAABB);
        op_load (SZ_H, 1'b0, 5'd9, 32'h20, 32'h0000AABB);
        op_load (SZ_H, 1'b1, 5'd7, 32'h22, 32'h00001234);
        op_load (SZ_B, 1'b1, 5'd8, 32'h23, 32'h00000034);
        op_load (SZ_W, 1'b0, 5'd10, 32'h1010, 32'hDEADBEEF);
        op_store(SZ_B, 32'h1013, 32'h00000077);
        op_load (SZ_W, 1'b0, 5'd11, 32'h10, 32'hDEADBE77);
        @(negedge Clk);
        check("align_clear", {63'd0, AlignErr}, 64'd0);

        op_load (SZ_W, 1'b0, 5'd8, 32'h13, 32'h0);
        op_store(SZ_W, 32'h12, 32'h11111111);
        op_load (SZ_W, 1'b0, 5'd9, 32'h10, 32'hDEADBE77);
        op_load (SZ_X, 1'b1, 5'd10, 32'h10, 32'h0);
        @(negedge Clk);
        check("align_set", {63'd0, AlignErr}, 64'd1);

        op_alu(5'd9, 32'h42);
        @(negedge Clk);
        check("fwd_data", {32'd0, MEM_FwdData}, 64'h42);
        check("fwd_dest", {58'd0, MEM_RegWrite, MEM_RegDest}, {58'd0, 1'b1, 5'd9});
        bubble(1);

        op_alu(5'd10, 32'h99);
        op_store(SZ_W, 32'h30, 32'hCAFEF00D);
        Stall = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SZ_W, 5'd0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge Clk);
            check("stall_wb_hold", {26'd0, WB_RegWrite, WB_RegDest, WB_WriteData}, {26'd0, 1'b1, 5'd10, 32'h99});
            check("stall_mem_hold", {32'd0, MEM_FwdData}, 64'h30);
        end
        Stall = 1'b0;
        bubble(1);
        op_load(SZ_W, 1'b0, 5'd12, 32'h30, 32'hCAFEF00D);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SZ_W, 5'd11, 32'h77, 32'd0);
        Flush = 1'b1;
        cyc();
        Flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SZ_W, 5'd0, 32'd0, 32'd0);
        @(negedge Clk);
        check("flush_mem", {31'd0, MEM_RegWrite, MEM_FwdData}, 64'd0);
        cyc();
        @(negedge Clk);
        check("flush_wb", {62'd0, WB_Valid, WB_RegWrite}, 64'd0);
        check("align_sticky", {63'd0, AlignErr}, 64'd1);

        // A store sitting in EX/MEM when reset hits must not commit.
        op_store(SZ_W, 32'h50, 32'h00000000);
        op_store(SZ_W, 32'h50, 32'hBAD0BAD0);
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SZ_W, 5'd0, 32'd0, 32'd0);
        cyc();
        sb.delete();
        @(negedge Clk);
        check("midreset_outs", {24'd0, WB_Valid, MEM_RegWrite, MEM_FwdData, WB_RegWrite, AlignErr, 5'd0},
              64'd0);
        Reset = 1'b0;
        op_load(SZ_W, 1'b0, 5'd13, 32'h50, 32'h00000000);
        bubble(3);
        @(negedge Clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage of the five-stage MIPS datapath. It consumes the Execute stage's outputs (ALU result, selected destination register, store data and control), registers them in an EX/MEM register, performs byte/half/word loads and stores against an internal data memory, and registers the write-back value in a MEM/WB register for the WB stage. It also exports the EX/MEM contents as forwarding sources for the hazard/forwarding unit.

## Interface
- DEPTH, 1024: data memory size in 32-bit words (power of two).
- ADDR_W, 10: log2(DEPTH).
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; sampled on rising edge of Clk.
- EX_Valid  in  1  EX outputs this cycle are a real instruction (0 = bubble).
- ALUResult  in  32  byte address for loads/stores; result value otherwise.
- StoreData  in  32  rt register value (Reg_Data2 path) for stores.
- RegDestSelected  in  5  destination register from the RegDst mux.
- RegWrite, MemRead, MemWrite, MemToReg, MemSigned  in  1 each  control from ID/EX.
- MemSize  in  2  00 word, 01 half, 10 byte, 11 illegal.
- Stall  in  1  freeze both pipeline registers this edge.
- Flush  in  1  load a bubble into EX/MEM this edge.
- MEM_RegWrite, MEM_RegDest, MEM_FwdData  out  1/5/32  forwarding source from EX/MEM (MEM_FwdData = registered ALUResult).
- WB_Valid, WB_RegWrite, WB_RegDest, WB_WriteData  out  1/1/5/32  MEM/WB register contents.
- AlignErr  out  1  sticky misaligned/illegal access flag.

## Operation
- EX/MEM register captures all EX inputs; MEM/WB register captures write-back results. Both are plain registered outputs.
- Effective valid of EX/MEM = registered EX_Valid; when 0, no memory write and MEM_RegWrite/WB_RegWrite forced 0.
- Word index = addr[ADDR_W+1:2]; upper address bits ignored (wrap modulo DEPTH words).
- Big-endian lanes: addr[1:0]=0 selects bits 31:24; half at addr[1]=0 selects 31:16.
- Alignment: word needs addr[1:0]=00, half needs addr[0]=0, byte always legal, MemSize=11 always illegal. An illegal access: store suppressed, load data = 0, AlignErr set (stays 1 until Reset), instruction otherwise retires normally.
- Store: byte replicated to all four lanes, half replicated to both halves; only the addressed lanes written (byte enables).
- Load: memory read is combinational from the EX/MEM address; selected lane zero- or sign-extended per MemSigned; word ignores MemSigned.
- WB_WriteData = MemToReg ? extended load data : registered ALUResult.
- Store to a word followed immediately by a load of that word: load sees new data (store committed at the edge before the load is in MEM).
- Priority per edge: Reset > Stall > Flush > normal capture.
  - Stall: both registers hold, no store commits, AlignErr unchanged.
  - Flush (no Stall): EX/MEM loads bubble; MEM/WB captures normally from the current EX/MEM.

## Timing
- Reset: all EX/MEM and MEM/WB fields 0, all outputs 0, AlignErr 0. Memory contents not cleared.
- Latency: EX inputs at edge k → MEM_* outputs after k; store commits and WB_* outputs valid after edge k+1 (2 edges EX→WB).
- Forwarding outputs valid one edge after capture, combinationally from EX/MEM, for the whole cycle.
- One instruction per cycle when Stall=0; no internal stalls.
- Reset asserted mid-stream discards in-flight instructions; a store in EX/MEM at that edge does not commit.

## Structure
- Shared package: MemSize encodings (SIZE_WORD, SIZE_HALF, SIZE_BYTE, SIZE_ILLEGAL) and EX/MEM and MEM/WB field widths.
- One sub-module: data_memory (DEPTH words, combinational read, synchronous write with 4-bit byte enable, no reset).
- Alignment check, lane select/extension and store-lane replication live in memory_stage.

## Test plan
- Reset with EX_Valid=1, RegWrite=1 held → all outputs 0 during and one cycle after reset release; WB_Valid rises two edges after release.
- SW 0xDEADBEEF to 0x10, then LW 0x10 next cycle → WB_WriteData=0xDEADBEEF two edges after LW issues; LB 0x11 signed → 0xFFFFFFAD; LBU 0x11 → 0x000000AD.
- SH 0x1234 to 0x22 over word 0xAABBCCDD at 0x20 → LW 0x20 returns 0xAABB1234; LH 0x20 signed → 0xFFFFAABB.
- LW at 0x13 and SW at 0x12 → AlignErr=1 sticky, LW write-back data 0, word at 0x10 unchanged.
- SW in EX/MEM with Stall=1 for 3 cycles, then Stall=0 → single commit, WB outputs frozen during stall; Flush with an ADD in EX → MEM_RegWrite=0 next cycle, WB_RegWrite=0 one cycle later.
- ALU ADD result 0x00000042, RegDest=9, MemToReg=0 → MEM_FwdData=0x42, MEM_RegDest=9 after 1 edge; WB_WriteData=0x42, WB_RegDest=9 after 2 edges; address 0x1010 aliases 0x0010 with DEPTH=1024.
